// File: rtl/uart_axis_pkg.sv
// Shared types and constants for the UART-to-AXI-Stream receiver.
// Also provides the helper used to size FIFO level counters.
package uart_axis_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int DATA_BITS = 8;

  // A level counter must represent 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_fifo.sv
// Synchronous show-ahead FIFO: pop_data is always the head entry.
// A push is accepted when full only if a pop happens in the same cycle.
module axis_fifo
  import uart_axis_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              pop_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == LW'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  assign pop_data = mem[rd_ptr];
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);

  // Storage is cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_axis.sv
// UART receiver (8N1, LSB first) feeding an AXI-Stream master through a FIFO.
// valid/ready: a byte transfers on any rising edge where tvalid and tready are both high.
module uart_rx_axis
  import uart_axis_pkg::*;
#(
  parameter int CLKS_PER_BIT    = 434,
  parameter int FIFO_DEPTH      = 8,
  parameter int AXIS_DATA_WIDTH = 8
) (
  input  logic                          axis_aclk_i,
  input  logic                          axis_reset_i,
  input  logic                          uart_rx_i,
  output logic                          m_axis_tvalid_o,
  input  logic                          m_axis_tready_i,
  output logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          frame_err_o,
  output logic                          overrun_o,
  output rx_state_t                     state_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rx_s;
  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 push;
  logic                 frame_err_d;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;

  assign state_o = state_q;

  always_ff @(posedge axis_aclk_i) begin
    if (axis_reset_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge axis_aclk_i) begin
    if (axis_reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_o <= frame_err_d;
      overrun_o   <= push && fifo_full && !pop;
    end
  end

  // Start bit is checked at its midpoint; every later sample lands mid-bit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) push = 1'b1;
          else      frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop             = m_axis_tvalid_o && m_axis_tready_i;
  assign m_axis_tvalid_o = !fifo_empty;

  axis_fifo #(
    .WIDTH (AXIS_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (axis_aclk_i),
    .rst       (axis_reset_i),
    .push      (push),
    .push_data (shift_q),
    .pop       (pop),
    .pop_data  (m_axis_tdata_o),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level_o)
  );

endmodule

// File: tb/tb_uart_rx_axis.sv
// Directed bench for uart_rx_axis with a short bit period.
// A negedge monitor scores every stream transfer and the error pulses.
module tb_uart_rx_axis;
  import uart_axis_pkg::*;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;
  localparam int GAP   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       tvalid;
  logic       tready = 1'b0;
  logic [7:0] tdata;
  logic [3:0] level;
  logic       frame_err;
  logic       overrun;
  rx_state_t  state;

  int n_checks = 0;
  int n_errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_axis #(
    .CLKS_PER_BIT    (CPB),
    .FIFO_DEPTH      (DEPTH),
    .AXIS_DATA_WIDTH (8)
  ) dut (
    .axis_aclk_i     (clk),
    .axis_reset_i    (rst),
    .uart_rx_i       (uart_rx),
    .m_axis_tvalid_o (tvalid),
    .m_axis_tready_i (tready),
    .m_axis_tdata_o  (tdata),
    .fifo_level_o    (level),
    .frame_err_o     (frame_err),
    .overrun_o       (overrun),
    .state_o         (state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clk); #1 uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 uart_rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    #1 uart_rx = stop;
    repeat (CPB) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (GAP) @(posedge clk);
  endtask

  task automatic pulse_ready();
    @(posedge clk); #1 tready = 1'b1;
    @(posedge clk); #1 tready = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  // Scoreboard and handshake/pulse-width monitor.
  logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_rst = 1'b1;
  logic       prev_fe = 1'b0, prev_ov = 1'b0;
  logic [7:0] prev_data = '0;
  logic [7:0] exp_b;
  always @(negedge clk) begin
    if (!rst && !prev_rst) begin
      if (prev_valid && !prev_ready) begin
        check("hold_valid", tvalid, 1);
        check("hold_data", tdata, prev_data);
      end
      if (tvalid && tready) begin
        check("pop_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_b = exp_q.pop_front();
          check("pop_data", tdata, exp_b);
        end
      end
      if (frame_err) begin
        fe_cnt++;
        check("fe_width", prev_fe, 0);
      end
      if (overrun) begin
        ov_cnt++;
        check("ov_width", prev_ov, 0);
      end
    end
    prev_valid = tvalid;
    prev_ready = tready;
    prev_data  = tdata;
    prev_rst   = rst;
    prev_fe    = frame_err;
    prev_ov    = overrun;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  int fe0;
  int ov0;

  initial begin
    // 1: reset with the line toggling
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 uart_rx = ~uart_rx;
      @(negedge clk);
      check("rst_valid", tvalid, 0);
      check("rst_data", tdata, 8'h00);
      check("rst_level", level, 0);
      check("rst_fe", frame_err, 0);
      check("rst_ov", overrun, 0);
    end
    @(posedge clk); #1 rst = 1'b0; uart_rx = 1'b1;
    repeat (40) @(posedge clk);
    check("idle_state", state, IDLE);
    check("idle_level", level, 0);

    // 2: single byte, tready tied high; push lands at cycle 155 of the frame
    tready = 1'b1;
    exp_q.push_back(8'hA5);
    fork
      send_byte(8'hA5, 1'b1);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        @(negedge clk);
        check("t2_valid_before", tvalid, 0);
        @(negedge clk);
        check("t2_valid_rise", tvalid, 1);
        check("t2_data", tdata, 8'hA5);
        @(negedge clk);
        check("t2_level_after", level, 0);
      end
    join
    check("t2_drained", exp_q.size(), 0);
    #1 tready = 1'b0;

    // 3: three bytes buffered, then drained one pulse at a time
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h3C);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h3C, 1'b1);
    @(negedge clk);
    check("t3_level", level, 3);
    check("t3_head", tdata, 8'h00);
    check("t3_valid", tvalid, 1);
    repeat (3) pulse_ready();
    @(negedge clk);
    check("t3_empty_valid", tvalid, 0);
    check("t3_drained", exp_q.size(), 0);

    // 4: short low glitch is rejected
    fe0 = fe_cnt;
    @(posedge clk); #1 uart_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("t4_state", state, IDLE);
    check("t4_level", level, 0);
    check("t4_fe", fe_cnt - fe0, 0);

    // 5: bad stop bit, then a good frame
    fe0 = fe_cnt;
    send_byte(8'h55, 1'b0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("t5_fe_count", fe_cnt - fe0, 1);
    check("t5_level", level, 0);
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1'b1);
    @(negedge clk);
    check("t5_level_good", level, 1);
    check("t5_head_good", tdata, 8'h12);
    pulse_ready();
    check("t5_drained", exp_q.size(), 0);

    // 6: overflow on the ninth byte, drain, then reset mid-frame
    ov0 = ov_cnt;
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1);
    end
    @(negedge clk);
    check("t6_ov_before", ov_cnt - ov0, 0);
    check("t6_level_full", level, DEPTH);
    send_byte(8'h09, 1'b1);
    @(negedge clk);
    check("t6_ov_count", ov_cnt - ov0, 1);
    check("t6_level_still_full", level, DEPTH);
    repeat (DEPTH) pulse_ready();
    @(negedge clk);
    check("t6_drained", exp_q.size(), 0);
    check("t6_empty_valid", tvalid, 0);

    send_byte(8'h21, 1'b1);
    send_byte(8'h22, 1'b1);
    @(negedge clk);
    check("t6_level_pre_rst", level, 2);
    @(posedge clk); #1 uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12 * CPB) @(posedge clk);
    @(negedge clk);
    check("t6_rst_level", level, 0);
    check("t6_rst_valid", tvalid, 0);
    check("t6_rst_data", tdata, 8'h00);
    check("t6_rst_state", state, IDLE);
    check("final_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
